// File: rtl/io_evt_pkg.sv
// Shared helpers and types for the IO event collector.
package io_evt_pkg;

  // Width of an event index; never narrower than one bit.
  function automatic int unsigned evt_id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned EVT_ID_MAX_W  = 16;
  localparam int unsigned EVT_CNT_MAX_W = 8;

  typedef logic [EVT_ID_MAX_W-1:0]  evt_id_t;
  typedef logic [EVT_CNT_MAX_W-1:0] evt_cnt_t;

  // One beat of the outgoing event stream.
  typedef struct packed {
    logic    valid;
    evt_id_t id;
  } evt_beat_t;

endpackage

// File: rtl/io_evt_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves past the winner only when the grant is actually taken (adv_en).
module io_evt_rr_arb
  import io_evt_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = evt_id_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             adv_en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W:0]   sum;

  // Pick the first requester at or after the pointer, wrapping N-1 -> 0.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum = {1'b0, ptr_reg} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      if (!gnt_valid && req[sum[IDX_W-1:0]]) begin
        gnt_valid                = 1'b1;
        gnt_idx                  = sum[IDX_W-1:0];
        gnt[sum[IDX_W-1:0]]      = 1'b1;
      end
    end
  end

  // Next pointer: one past the taken grant, otherwise hold.
  always_comb begin
    ptr_next = ptr_reg;
    if (adv_en && gnt_valid) begin
      ptr_next = (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/io_event_collector.sv
// IO event collector: per-source saturating pending counters, round-robin
// selection and an ID FIFO feeding a valid/ready stream; drops are flagged.
module io_event_collector
  import io_evt_pkg::*;
#(
  parameter  int unsigned N_EVT      = 128,
  parameter  int unsigned FIFO_DEPTH = 8,
  parameter  int unsigned CNT_W      = 2,
  localparam int unsigned ID_W       = evt_id_w(N_EVT),
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH+1)
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_ni,
  input  logic [N_EVT-1:0] evt_i,
  input  logic [N_EVT-1:0] evt_mask_i,
  input  logic             clr_ovf_i,
  output logic             evt_valid_o,
  output logic [ID_W-1:0]  evt_id_o,
  input  logic             evt_ready_i,
  output logic [N_EVT-1:0] ovf_o,
  output logic [LVL_W-1:0] fifo_level_o
);

  localparam int unsigned    PTR_W   = (FIFO_DEPTH <= 1) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_EVT-1:0] req, gnt, gnt_eff, ovf_set, ovf_reg;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any, grant_en, push, pop, full;

  logic [ID_W-1:0]  mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg, level_next;

  // A grant is only taken when its ID has room in the FIFO this cycle.
  assign pop      = (level_reg != '0) && evt_ready_i;
  assign full     = (level_reg == LVL_W'(FIFO_DEPTH));
  assign grant_en = !full || pop;
  assign push     = gnt_any && grant_en;
  assign gnt_eff  = gnt & {N_EVT{grant_en}};

  io_evt_rr_arb #(.N(N_EVT)) u_arb (
    .clk       (sys_clk_i),
    .rst_n     (sys_rst_ni),
    .req       (req),
    .adv_en    (grant_en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < int'(N_EVT); gi++) begin : g_src
      logic             inc, dec;
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      assign inc         = evt_i[gi] & ~evt_mask_i[gi];
      assign dec         = gnt_eff[gi];
      assign req[gi]     = (cnt_reg != '0);
      assign ovf_set[gi] = inc & ~dec & (cnt_reg == CNT_MAX);

      // Saturating pending count; a simultaneous strobe and grant cancel out.
      always_comb begin
        cnt_next = cnt_reg;
        if (inc && !dec && cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
        else if (dec && !inc)                  cnt_next = cnt_reg - 1'b1;
      end

      // Pending count register.
      always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) cnt_reg <= '0;
        else             cnt_reg <= cnt_next;
      end
    end
  endgenerate

  // Sticky overflow flags; a fresh overflow beats a clear in the same cycle.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) ovf_reg <= '0;
    else             ovf_reg <= (ovf_reg & ~{N_EVT{clr_ovf_i}}) | ovf_set;
  end

  // FIFO occupancy bookkeeping.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // FIFO pointers and level.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  // FIFO storage; contents need no reset because the level qualifies them.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem_reg[wr_ptr_reg] <= gnt_idx;
  end

  assign evt_valid_o  = (level_reg != '0);
  assign evt_id_o     = evt_valid_o ? mem_reg[rd_ptr_reg] : '0;
  assign ovf_o        = ovf_reg;
  assign fifo_level_o = level_reg;

endmodule

// File: tb/tb_io_event_collector.sv
// Bench for io_event_collector: directed scenarios plus random traffic, all
// compared every cycle against a queue/array reference model.
module tb_io_event_collector;

  localparam int N    = 8;
  localparam int D    = 4;
  localparam int MAXC = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] evt   = '0;
  logic [7:0] mask  = '0;
  logic       clr   = 1'b0;
  logic       ready = 1'b0;
  logic       valid;
  logic [2:0] id;
  logic [7:0] ovf;
  logic [2:0] level;

  io_event_collector #(.N_EVT(8), .FIFO_DEPTH(4), .CNT_W(2)) dut (
    .sys_clk_i    (clk),
    .sys_rst_ni   (rst_n),
    .evt_i        (evt),
    .evt_mask_i   (mask),
    .clr_ovf_i    (clr),
    .evt_valid_o  (valid),
    .evt_id_o     (id),
    .evt_ready_i  (ready),
    .ovf_o        (ovf),
    .fifo_level_o (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         m_cnt [N];
  int         m_ptr;
  int         m_q[$];
  logic [7:0] m_ovf;
  int         m_dropped;
  int         accepted;
  int         dlog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int at(input int i);
    return (i < dlog.size()) ? dlog[i] : -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_ptr = 0;
    m_q.delete();
    m_ovf = '0;
  endtask

  // One clock of the reference: pop, pick winner, update counts, push.
  task automatic model_step();
    bit         pop, can, inc;
    int         g, k;
    logic [7:0] newovf;
    pop = (m_q.size() > 0) && ready;
    can = (m_q.size() < D) || pop;
    g   = -1;
    if (can) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (g < 0 && m_cnt[k] > 0) g = k;
      end
    end
    newovf = '0;
    for (int s = 0; s < N; s++) begin
      inc = evt[s] && !mask[s];
      if (inc && s != g) begin
        if (m_cnt[s] == MAXC) begin
          newovf[s] = 1'b1;
          m_dropped++;
        end else begin
          m_cnt[s]++;
        end
      end else if (!inc && s == g) begin
        m_cnt[s]--;
      end
    end
    m_ovf = clr ? newovf : (m_ovf | newovf);
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic step();
    if (valid && ready) begin
      dlog.push_back(int'(id));
      $display("beat id=%0d t=%0t", id, $time);
    end
    accepted += $countones(evt & ~mask);
    @(posedge clk);
    model_step();
    #1;
    chk("valid", valid, m_q.size() > 0);
    chk("level", level, m_q.size());
    chk("ovf", ovf, m_ovf);
    if (m_q.size() > 0) chk("id", id, m_q[0]);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int c2;
    model_reset();
    m_dropped = 0;
    accepted  = 0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_level", level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin from pointer 0
    ready = 1'b1; dlog.delete();
    evt = 8'h81; step(); evt = '0; steps(5);
    chk("rr1_n", dlog.size(), 2);
    chk("rr1_a", at(0), 0);
    chk("rr1_b", at(1), 7);

    // Single strobe and its latency
    dlog.delete();
    evt = 8'h20; step(); evt = '0;
    chk("single_lat1", valid, 0);
    step();
    chk("single_lat2", valid, 1);
    chk("single_id", id, 5);
    steps(4);
    chk("single_n", dlog.size(), 1);
    chk("single_log", at(0), 5);

    // Round-robin with the pointer past 0
    dlog.delete();
    evt = 8'h81; step(); evt = '0; steps(5);
    chk("rr2_n", dlog.size(), 2);
    chk("rr2_a", at(0), 7);
    chk("rr2_b", at(1), 0);

    // Saturation and overflow on source 2
    ready = 1'b0;
    evt = 8'h04; steps(10); evt = '0; step();
    chk("sat_level", level, 4);
    chk("sat_ovf2", ovf[2], 1);
    ready = 1'b1; dlog.delete(); steps(12);
    chk("sat_beats", dlog.size(), 7);
    c2 = 0;
    foreach (dlog[i]) if (dlog[i] == 2) c2++;
    chk("sat_id2", c2, 7);
    clr = 1'b1; step(); clr = 1'b0;
    chk("sat_clr", ovf, 0);

    // Masking
    dlog.delete();
    mask = 8'h08; evt = 8'h08; step(); evt = '0; steps(4);
    chk("mask_none", dlog.size(), 0);
    mask = '0; ready = 1'b0;
    evt = 8'h08; step(); evt = '0; mask = 8'h08; steps(3);
    ready = 1'b1; steps(4);
    chk("mask_pend_n", dlog.size(), 1);
    chk("mask_pend_id", at(0), 3);
    mask = '0;

    // Overflow colliding with clear on source 1
    ready = 1'b0;
    evt = 8'h02; steps(7);
    chk("coll_pre", ovf[1], 0);
    clr = 1'b1; step(); clr = 1'b0; evt = '0;
    chk("coll_ovf1", ovf[1], 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("coll_clr", ovf, 0);
    ready = 1'b1; steps(10);
    chk("coll_drain", valid, 0);

    // Asynchronous reset with queued events
    ready = 1'b0;
    evt = 8'h07; step(); evt = '0; steps(4);
    chk("ar_level", level, 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_valid", valid, 0);
    chk("ar_lvl0", level, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    ready = 1'b1; dlog.delete(); steps(6);
    chk("ar_stale", dlog.size(), 0);

    // Random traffic
    dlog.delete(); accepted = 0; m_dropped = 0;
    for (int i = 0; i < 400; i++) begin
      evt   = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      mask  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    evt = '0; mask = '0; clr = 1'b0; ready = 1'b1;
    steps(40);
    chk("rnd_idle", valid, 0);
    chk("rnd_conserve", dlog.size(), accepted - m_dropped);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
